// File: rtl/rename_stage.sv
// Dual-issue register rename stage: pops destinations from the free list, translates
// sources/destinations through the speculative RAT, and restores the RAT during rollback.
module rename_stage #(
  parameter int unsigned L_REGISTERS = 32,
  parameter int unsigned P_REGISTERS = 128,
  parameter int unsigned PR_WIDTH    = 7,
  localparam int unsigned LW         = $clog2(L_REGISTERS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ins_valid_1,
  input  logic                  ins_valid_2,
  output logic                  ins_ready,
  input  logic [LW-1:0]         src1_1,
  input  logic [LW-1:0]         src2_1,
  input  logic [LW-1:0]         dst_1,
  input  logic [LW-1:0]         src1_2,
  input  logic [LW-1:0]         src2_2,
  input  logic [LW-1:0]         dst_2,
  input  logic                  dst_en_1,
  input  logic                  dst_en_2,
  input  logic [PR_WIDTH-1:0]   fl_pop_data_1,
  input  logic [PR_WIDTH-1:0]   fl_pop_data_2,
  input  logic                  fl_valid_1,
  input  logic                  fl_valid_2,
  output logic                  fl_pop_1,
  output logic                  fl_pop_2,
  output logic                  fl_push,
  output logic                  fl_push_2,
  output logic [PR_WIDTH-1:0]   fl_push_data,
  output logic [PR_WIDTH-1:0]   fl_push_data_2,
  input  logic                  fl_ready,
  output logic [1:0]            out_valid,
  input  logic                  out_ready,
  output logic [2*PR_WIDTH-1:0] out_psrc1,
  output logic [2*PR_WIDTH-1:0] out_psrc2,
  output logic [2*PR_WIDTH-1:0] out_pdst,
  output logic [2*PR_WIDTH-1:0] out_old_pdst,
  input  logic                  commit_valid,
  input  logic [PR_WIDTH-1:0]   commit_old_pdst,
  input  logic                  rollback_mode,
  input  logic                  rb_valid,
  input  logic [LW-1:0]         rb_ldst,
  input  logic [PR_WIDTH-1:0]   rb_pdst,
  input  logic [PR_WIDTH-1:0]   rb_old_pdst,
  input  logic                  flush
);

  logic [PR_WIDTH-1:0]   rat_q [L_REGISTERS];
  logic [PR_WIDTH-1:0]   rat_d [L_REGISTERS];

  logic [1:0]            out_valid_q, out_valid_d;
  logic [2*PR_WIDTH-1:0] out_psrc1_q, out_psrc1_d;
  logic [2*PR_WIDTH-1:0] out_psrc2_q, out_psrc2_d;
  logic [2*PR_WIDTH-1:0] out_pdst_q, out_pdst_d;
  logic [2*PR_WIDTH-1:0] out_old_pdst_q, out_old_pdst_d;

  logic                  has_dst_1, has_dst_2;
  logic                  need_any, need_two, sufficient, fire;
  logic [PR_WIDTH-1:0]   new_pdst_1, new_pdst_2;
  logic [PR_WIDTH-1:0]   psrc1_1, psrc2_1, psrc1_2, psrc2_2;
  logic [PR_WIDTH-1:0]   pdst_1, pdst_2, old_pdst_1, old_pdst_2;

  // Handshake: destination demand vs. free-list depth, output slot availability.
  always_comb begin
    has_dst_1  = dst_en_1 && (dst_1 != '0);
    has_dst_2  = ins_valid_2 && dst_en_2 && (dst_2 != '0);
    need_two   = has_dst_1 && has_dst_2;
    need_any   = has_dst_1 || has_dst_2;
    sufficient = need_two ? fl_valid_2 : (need_any ? fl_valid_1 : 1'b1);
    ins_ready  = !rst && !rollback_mode && !flush
                 && (!(|out_valid_q) || out_ready) && sufficient;
    fire       = ins_valid_1 && ins_ready;
    fl_pop_1   = fire && need_any;
    fl_pop_2   = fire && need_two;
  end

  // Free-list returns: retire frees the old mapping, rollback frees the squashed one.
  always_comb begin
    fl_push        = !rst && commit_valid;
    fl_push_data   = commit_old_pdst;
    fl_push_2      = !rst && rb_valid;
    fl_push_data_2 = rb_pdst;
  end

  // Translation. A lone destination always consumes the first free-list head.
  always_comb begin
    new_pdst_1 = fl_pop_data_1;
    new_pdst_2 = has_dst_1 ? fl_pop_data_2 : fl_pop_data_1;

    psrc1_1 = (src1_1 == '0) ? '0 : rat_q[src1_1];
    psrc2_1 = (src2_1 == '0) ? '0 : rat_q[src2_1];

    if (has_dst_1 && (src1_2 == dst_1)) begin
      psrc1_2 = new_pdst_1;
    end else begin
      psrc1_2 = (src1_2 == '0) ? '0 : rat_q[src1_2];
    end
    if (has_dst_1 && (src2_2 == dst_1)) begin
      psrc2_2 = new_pdst_1;
    end else begin
      psrc2_2 = (src2_2 == '0) ? '0 : rat_q[src2_2];
    end

    pdst_1     = has_dst_1 ? new_pdst_1 : '0;
    old_pdst_1 = has_dst_1 ? rat_q[dst_1] : '0;
    pdst_2     = has_dst_2 ? new_pdst_2 : '0;
    if (!has_dst_2) begin
      old_pdst_2 = '0;
    end else if (has_dst_1 && (dst_2 == dst_1)) begin
      old_pdst_2 = new_pdst_1;
    end else begin
      old_pdst_2 = rat_q[dst_2];
    end
  end

  // Output slot: load on fire, otherwise drain on ready or flush, otherwise hold.
  always_comb begin
    out_valid_d    = out_valid_q;
    out_psrc1_d    = out_psrc1_q;
    out_psrc2_d    = out_psrc2_q;
    out_pdst_d     = out_pdst_q;
    out_old_pdst_d = out_old_pdst_q;
    if (fire) begin
      out_valid_d    = {ins_valid_2, 1'b1};
      out_psrc1_d    = {psrc1_2, psrc1_1};
      out_psrc2_d    = {psrc2_2, psrc2_1};
      out_pdst_d     = {pdst_2, pdst_1};
      out_old_pdst_d = {old_pdst_2, old_pdst_1};
    end else if (flush || out_ready) begin
      out_valid_d = 2'b00;
    end
  end

  // RAT update: slot 2 is written last so it owns a shared ldst; x0 is never remapped.
  always_comb begin
    rat_d = rat_q;
    if (fire && has_dst_1) begin
      rat_d[dst_1] = new_pdst_1;
    end
    if (fire && has_dst_2) begin
      rat_d[dst_2] = new_pdst_2;
    end
    if (rb_valid && (rb_ldst != '0)) begin
      rat_d[rb_ldst] = rb_old_pdst;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < L_REGISTERS; i++) begin
        rat_q[i] <= PR_WIDTH'(i);
      end
      out_valid_q    <= 2'b00;
      out_psrc1_q    <= '0;
      out_psrc2_q    <= '0;
      out_pdst_q     <= '0;
      out_old_pdst_q <= '0;
    end else begin
      rat_q          <= rat_d;
      out_valid_q    <= out_valid_d;
      out_psrc1_q    <= out_psrc1_d;
      out_psrc2_q    <= out_psrc2_d;
      out_pdst_q     <= out_pdst_d;
      out_old_pdst_q <= out_old_pdst_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_psrc1    = out_psrc1_q;
  assign out_psrc2    = out_psrc2_q;
  assign out_pdst     = out_pdst_q;
  assign out_old_pdst = out_old_pdst_q;

  // The free list is sized so it can never overflow; a push into a full list is an upstream bug.
  a_push_not_full: assert property (@(posedge clk) disable iff (rst)
    (fl_push || fl_push_2) |-> fl_ready);
  a_rb_pdst_range: assert property (@(posedge clk) disable iff (rst)
    rb_valid |-> (32'(rb_pdst) < P_REGISTERS));

endmodule

// File: tb/tb_rename_stage.sv
// Randomized bench for rename_stage against a sequential per-instruction rename model.
module tb_rename_stage;
  localparam int unsigned PW = 7;
  localparam int unsigned LW = 5;

  logic clk = 1'b0;
  logic rst;
  logic ins_valid_1, ins_valid_2, ins_ready;
  logic [LW-1:0] src1_1, src2_1, dst_1, src1_2, src2_2, dst_2;
  logic dst_en_1, dst_en_2;
  logic [PW-1:0] fl_pop_data_1, fl_pop_data_2;
  logic fl_valid_1, fl_valid_2, fl_pop_1, fl_pop_2;
  logic fl_push, fl_push_2;
  logic [PW-1:0] fl_push_data, fl_push_data_2;
  logic fl_ready;
  logic [1:0] out_valid;
  logic out_ready;
  logic [2*PW-1:0] out_psrc1, out_psrc2, out_pdst, out_old_pdst;
  logic commit_valid;
  logic [PW-1:0] commit_old_pdst;
  logic rollback_mode, rb_valid;
  logic [LW-1:0] rb_ldst;
  logic [PW-1:0] rb_pdst, rb_old_pdst;
  logic flush;

  rename_stage dut (
    .clk(clk), .rst(rst),
    .ins_valid_1(ins_valid_1), .ins_valid_2(ins_valid_2), .ins_ready(ins_ready),
    .src1_1(src1_1), .src2_1(src2_1), .dst_1(dst_1),
    .src1_2(src1_2), .src2_2(src2_2), .dst_2(dst_2),
    .dst_en_1(dst_en_1), .dst_en_2(dst_en_2),
    .fl_pop_data_1(fl_pop_data_1), .fl_pop_data_2(fl_pop_data_2),
    .fl_valid_1(fl_valid_1), .fl_valid_2(fl_valid_2),
    .fl_pop_1(fl_pop_1), .fl_pop_2(fl_pop_2),
    .fl_push(fl_push), .fl_push_2(fl_push_2),
    .fl_push_data(fl_push_data), .fl_push_data_2(fl_push_data_2),
    .fl_ready(fl_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_psrc1(out_psrc1), .out_psrc2(out_psrc2),
    .out_pdst(out_pdst), .out_old_pdst(out_old_pdst),
    .commit_valid(commit_valid), .commit_old_pdst(commit_old_pdst),
    .rollback_mode(rollback_mode), .rb_valid(rb_valid),
    .rb_ldst(rb_ldst), .rb_pdst(rb_pdst), .rb_old_pdst(rb_old_pdst),
    .flush(flush)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [PW-1:0] rat_m [32];
  logic [1:0]    m_ov;
  logic [PW-1:0] m_ps1 [2];
  logic [PW-1:0] m_ps2 [2];
  logic [PW-1:0] m_pd  [2];
  logic [PW-1:0] m_old [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) rat_m[i] = PW'(i);
    m_ov = 2'b00;
    for (int s = 0; s < 2; s++) begin
      m_ps1[s] = '0; m_ps2[s] = '0; m_pd[s] = '0; m_old[s] = '0;
    end
  endtask

  task automatic idle();
    ins_valid_1 = 0; ins_valid_2 = 0;
    src1_1 = '0; src2_1 = '0; dst_1 = '0; src1_2 = '0; src2_2 = '0; dst_2 = '0;
    dst_en_1 = 0; dst_en_2 = 0;
    fl_pop_data_1 = '0; fl_pop_data_2 = '0; fl_valid_1 = 1; fl_valid_2 = 1;
    fl_ready = 1; out_ready = 1; commit_valid = 0; commit_old_pdst = '0;
    rollback_mode = 0; rb_valid = 0; rb_ldst = '0; rb_pdst = '0; rb_old_pdst = '0;
    flush = 0;
  endtask

  // Called at a negedge with inputs applied; checks this cycle's handshake, then the registered slot.
  task automatic step();
    logic          hd [2];
    logic [LW-1:0] sa, sb, d;
    logic          rdy, fire, suff;
    int            need, k;
    logic [PW-1:0] np;
    #1;
    hd[0] = dst_en_1 && (dst_1 != 0);
    hd[1] = ins_valid_2 && dst_en_2 && (dst_2 != 0);
    need  = int'(hd[0]) + int'(hd[1]);
    suff  = (need == 2) ? fl_valid_2 : ((need == 1) ? fl_valid_1 : 1'b1);
    rdy   = !rst && !rollback_mode && !flush && ((m_ov == 0) || out_ready) && suff;
    fire  = ins_valid_1 && rdy;
    check("ins_ready", 32'(ins_ready), 32'(rdy));
    check("fl_pop_1", 32'(fl_pop_1), 32'(fire && need >= 1));
    check("fl_pop_2", 32'(fl_pop_2), 32'(fire && need == 2));
    check("fl_push", 32'(fl_push), 32'(!rst && commit_valid));
    if (!rst && commit_valid) check("fl_push_data", 32'(fl_push_data), 32'(commit_old_pdst));
    check("fl_push_2", 32'(fl_push_2), 32'(!rst && rb_valid));
    if (!rst && rb_valid) check("fl_push_data_2", 32'(fl_push_data_2), 32'(rb_pdst));

    if (rst) begin
      model_reset();
    end else begin
      if (fire) begin
        k = 0;
        for (int s = 0; s < 2; s++) begin
          if (s == 1 && !ins_valid_2) continue;
          sa = (s == 0) ? src1_1 : src1_2;
          sb = (s == 0) ? src2_1 : src2_2;
          d  = (s == 0) ? dst_1  : dst_2;
          m_ps1[s] = (sa == 0) ? '0 : rat_m[sa];
          m_ps2[s] = (sb == 0) ? '0 : rat_m[sb];
          if (hd[s]) begin
            np = (k == 0) ? fl_pop_data_1 : fl_pop_data_2;
            k++;
            m_old[s] = rat_m[d];
            rat_m[d] = np;
            m_pd[s]  = np;
          end else begin
            m_old[s] = '0;
            m_pd[s]  = '0;
          end
        end
        m_ov = {ins_valid_2, 1'b1};
      end else if (flush || out_ready) begin
        m_ov = 2'b00;
      end
      if (rb_valid) rat_m[rb_ldst] = rb_old_pdst;
    end

    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_ov));
    for (int s = 0; s < 2; s++) begin
      if (m_ov[s]) begin
        check("out_psrc1", 32'(out_psrc1[s*PW +: PW]), 32'(m_ps1[s]));
        check("out_psrc2", 32'(out_psrc2[s*PW +: PW]), 32'(m_ps2[s]));
        check("out_pdst", 32'(out_pdst[s*PW +: PW]), 32'(m_pd[s]));
        check("out_old_pdst", 32'(out_old_pdst[s*PW +: PW]), 32'(m_old[s]));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    @(negedge clk);
    step();
    step();
    check("rst_psrc1", 32'(out_psrc1), 0);
    check("rst_pdst", 32'(out_pdst), 0);
    check("rst_old_pdst", 32'(out_old_pdst), 0);
    rst = 0;
    step();

    // add x5,x1,x2 then a read of x5
    ins_valid_1 = 1; src1_1 = 1; src2_1 = 2; dst_1 = 5; dst_en_1 = 1; fl_pop_data_1 = 32;
    step();
    check("tp1_valid", 32'(out_valid), 1);
    check("tp1_psrc1", 32'(out_psrc1[PW-1:0]), 1);
    check("tp1_psrc2", 32'(out_psrc2[PW-1:0]), 2);
    check("tp1_pdst", 32'(out_pdst[PW-1:0]), 32);
    check("tp1_old", 32'(out_old_pdst[PW-1:0]), 5);
    src1_1 = 5; dst_en_1 = 0;
    step();
    check("tp1_bypass_rat", 32'(out_psrc1[PW-1:0]), 32);

    // dual issue with intra-group dependency on x3
    idle();
    ins_valid_1 = 1; ins_valid_2 = 1; dst_1 = 3; dst_en_1 = 1;
    src1_2 = 3; dst_2 = 3; dst_en_2 = 1; fl_pop_data_1 = 40; fl_pop_data_2 = 41;
    step();
    check("tp2_psrc1_2", 32'(out_psrc1[2*PW-1:PW]), 40);
    check("tp2_old_2", 32'(out_old_pdst[2*PW-1:PW]), 40);
    check("tp2_pdst_2", 32'(out_pdst[2*PW-1:PW]), 41);
    idle();
    ins_valid_1 = 1; src1_1 = 3;
    step();
    check("tp2_rat3", 32'(out_psrc1[PW-1:0]), 41);

    // starvation, then release
    idle();
    ins_valid_1 = 1; ins_valid_2 = 1; dst_1 = 10; dst_en_1 = 1; dst_2 = 11; dst_en_2 = 1;
    fl_pop_data_1 = 60; fl_pop_data_2 = 61; fl_valid_2 = 0;
    step();
    step();
    fl_valid_2 = 1;
    step();

    // backpressure with a held slot
    ins_valid_2 = 0; dst_1 = 12; fl_pop_data_1 = 62;
    step();
    out_ready = 0; dst_1 = 13; fl_pop_data_1 = 63;
    for (int i = 0; i < 3; i++) step();
    out_ready = 1;
    step();

    // rename x7 -> 50, then roll it back with a coincident commit
    idle();
    ins_valid_1 = 1; dst_1 = 7; dst_en_1 = 1; fl_pop_data_1 = 50;
    step();
    idle();
    ins_valid_1 = 1; rollback_mode = 1; rb_valid = 1; rb_ldst = 7; rb_pdst = 50; rb_old_pdst = 7;
    commit_valid = 1; commit_old_pdst = 9;
    step();
    idle();
    ins_valid_1 = 1; src1_1 = 7;
    step();
    check("tp5_rat7", 32'(out_psrc1[PW-1:0]), 7);

    // x0 destination, then flush of a held dual slot
    idle();
    ins_valid_1 = 1; dst_1 = 0; dst_en_1 = 1; fl_pop_data_1 = 70;
    step();
    check("tp6_x0_pdst", 32'(out_pdst[PW-1:0]), 0);
    ins_valid_2 = 1; dst_1 = 20; dst_2 = 21; dst_en_2 = 1; fl_pop_data_1 = 71; fl_pop_data_2 = 72;
    step();
    idle();
    out_ready = 0;
    step();
    flush = 1;
    step();
    check("tp6_flush", 32'(out_valid), 0);
    idle();
    step();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      rst           = ($urandom_range(0, 299) == 0);
      ins_valid_1   = ($urandom_range(0, 3) != 0);
      ins_valid_2   = ins_valid_1 && $urandom_range(0, 1);
      src1_1 = LW'($urandom); src2_1 = LW'($urandom); dst_1 = LW'($urandom);
      src1_2 = LW'($urandom); src2_2 = LW'($urandom); dst_2 = LW'($urandom);
      if ($urandom_range(0, 3) == 0) src1_2 = dst_1;
      if ($urandom_range(0, 3) == 0) dst_2 = dst_1;
      dst_en_1      = ($urandom_range(0, 3) != 0);
      dst_en_2      = ($urandom_range(0, 3) != 0);
      fl_pop_data_1 = PW'($urandom);
      fl_pop_data_2 = PW'($urandom);
      fl_valid_1    = ($urandom_range(0, 5) != 0);
      fl_valid_2    = fl_valid_1 && ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 19) == 0);
      commit_valid  = $urandom_range(0, 1);
      commit_old_pdst = PW'($urandom);
      rollback_mode = ($urandom_range(0, 7) == 0);
      rb_valid      = rollback_mode && $urandom_range(0, 1);
      rb_ldst       = LW'($urandom_range(1, 31));
      rb_pdst       = PW'($urandom);
      rb_old_pdst   = PW'($urandom);
      step();
    end
    rst = 0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Dual-issue register rename stage that sits directly downstream of the physical-register free list.
- Each cycle it takes up to two decoded instructions, pops destination physical registers from the free list, and translates source and destination logical registers through a speculative alias table (RAT). It issues renamed instructions to dispatch through a registered output slot.
- It returns freed physical registers to the free list on commit (old mapping) and on rollback (squashed mapping). During rollback it restores the RAT entry by entry.

Parameters:
- L_REGISTERS, 32: logical registers; index width LW = $clog2(L_REGISTERS).
- P_REGISTERS, 128: physical registers.
- PR_WIDTH, 7: physical register index width; must satisfy 2**PR_WIDTH >= P_REGISTERS.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ins_valid_1, ins_valid_2  in  1 each  decoded instruction valid; slot 2 is valid only if slot 1 is valid.
- ins_ready  out  1  group accepted this cycle when ins_valid_1 & ins_ready.
- src1_1, src2_1, dst_1, src1_2, src2_2, dst_2  in  LW each  logical register indices.
- dst_en_1, dst_en_2  in  1 each  instruction writes a destination.
- fl_pop_data_1, fl_pop_data_2  in  PR_WIDTH each  free list heads.
- fl_valid_1, fl_valid_2  in  1 each  at least one / at least two free entries.
- fl_pop_1, fl_pop_2  out  1 each  free list pops.
- fl_push, fl_push_2  out  1 each  free list pushes (commit, rollback).
- fl_push_data, fl_push_data_2  out  PR_WIDTH each  freed registers.
- fl_ready  in  1  free list not full.
- out_valid  out  2  per-slot renamed valid.
- out_ready  in  1  dispatch accepts the output slot.
- out_psrc1, out_psrc2, out_pdst, out_old_pdst  out  2xPR_WIDTH each  renamed fields, slot-indexed.
- commit_valid  in  1  ROB retires an instruction with destination.
- commit_old_pdst  in  PR_WIDTH  register freed on retire.
- rollback_mode  in  1  ROB walk in progress; rename is blocked.
- rb_valid  in  1  one squashed entry this cycle, youngest first.
- rb_ldst  in  LW  squashed entry's logical destination.
- rb_pdst  in  PR_WIDTH  squashed entry's physical destination.
- rb_old_pdst  in  PR_WIDTH  squashed entry's previous mapping.
- flush  in  1  kill the output slot.

Behaviour:
- Reset (synchronous):
  - rat[i] = i for all i.
  - out_valid = 0; all out_* data fields = 0.
  - fl_pop_* = 0, fl_push_* = 0.
  - ins_ready = 0 while rst is high.
- x0 handling: dst index 0, or dst_en = 0, counts as "no destination". Such a slot does not pop, and reports out_pdst = out_old_pdst = 0. Source index 0 always maps to physical 0.
- need = number of slots with a destination (0, 1 or 2).
- Free-list sufficiency:
  - need = 2 requires fl_valid_2.
  - need = 1 requires fl_valid_1.
  - need = 0 is always sufficient.
- ins_ready = ~rst & ~rollback_mode & ~flush & (~out_valid_any | out_ready) & sufficient.
- Fire = ins_valid_1 & ins_ready. On fire:
  - need = 2: assert fl_pop_1 and fl_pop_2. Slot 1 takes fl_pop_data_1; slot 2 takes fl_pop_data_2.
  - need = 1: assert fl_pop_1 only; the needing slot takes fl_pop_data_1.
  - fl_pop_2 is never asserted alone.
- Intra-group bypass:
  - Slot 2 sources equal to slot 1's dst (slot 1 has a destination) take slot 1's new pdst.
  - If both slots write the same ldst, slot 2's out_old_pdst = slot 1's new pdst, and the RAT ends with slot 2's pdst.
- Latency: one cycle. The output register loads on fire; RAT updates on the same edge.
- Output slot:
  - Holds its value while out_valid_any & ~out_ready.
  - Clears when out_ready and no fire.
  - flush clears out_valid next cycle regardless of out_ready. The ROB is responsible for freeing the flushed registers through rollback.
- Commit: fl_push = commit_valid and fl_push_data = commit_old_pdst, combinational and same cycle. The RAT is unchanged.
- Rollback: when rb_valid, rat[rb_ldst] <= rb_old_pdst, fl_push_2 = 1 and fl_push_data_2 = rb_pdst, combinational and same cycle.
- commit and rb_valid may coincide; both pushes are issued in the same cycle.
- fl_ready: the free list is never overfilled by construction. Pushing while fl_ready = 0 is an assertion failure, not handled.
- rst overrides everything, including a pending rollback and a held output.

Test Plan:
- Reset then idle: after reset, instruction add x5,x1,x2 (dst_en) with fl_pop_data_1 = 32 → one cycle later out_valid = 01, psrc1 = 1, psrc2 = 2, pdst = 32, old_pdst = 5, fl_pop_1 = 1, fl_pop_2 = 0; next rename of src x5 yields psrc 32.
- Dual with dependency: slot 1 dst x3, slot 2 src1 x3 and dst x3, free heads 40/41 → slot 2 psrc1 = 40, slot 2 old_pdst = 40, pdst = 41; RAT[3] = 41; both pops asserted.
- Free list starvation: need = 2 with fl_valid_1 = 1, fl_valid_2 = 0 → ins_ready = 0, no pops, RAT unchanged. Raise fl_valid_2 → fire next cycle.
- Backpressure: out_ready = 0 for 3 cycles with a held output → output fields stable, ins_ready = 0, no pops. out_ready = 1 → new group accepted the same cycle.
- Rollback: RAT[7] = 50 after rename (old 7); rollback_mode = 1, rb_valid with ldst = 7, pdst = 50, old_pdst = 7 → fl_push_2 = 1 with data 50, RAT[7] = 7, ins_ready = 0 throughout. Concurrent commit_valid with old_pdst = 9 → fl_push = 1 with data 9 in the same cycle.
- x0 and flush: dst x0 → no pop, pdst = 0. flush asserted while out_valid = 11 and out_ready = 0 → out_valid = 00 next cycle.
